serial_twos_complement_adder: RTL and testbench

//  Bit-serial WIDTH-bit two's-complement adder with signed-overflow detection.

---
 rtl/serial_twos_complement_adder.sv | 126 ++++++++++++
 tb/tb_serial_twos_complement_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_complement_adder.sv
// Bit-serial two's-complement adder: one full-adder stage processes a+b LSB first,
// one bit per clock, between a valid/ready operand handshake and a valid/ready result handshake.
module serial_twos_complement_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             sum_bit_s;
  logic             carry_nxt_s;

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice on the current LSBs of the operand shift registers
  always_comb begin
    sum_bit_s   = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    carry_nxt_s = majority3(a_sh_r[0], b_sh_r[0], carry_r);
  end

  // Control FSM and datapath; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_r       <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_r      <= a;
            b_sh_r      <= b;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sum_r   <= {sum_bit_s, sum_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= carry_nxt_s;
          // On the MSB, carry_r is the carry into the MSB and carry_nxt_s the carry out
          if (cnt_r == CNT_LAST) begin
            carry_out_r <= carry_nxt_s;
            overflow_r  <= carry_nxt_s ^ carry_r;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_twos_complement_adder.sv
// Self-checking bench: WIDTH=4 directed cases plus WIDTH=8 randomized traffic,
// both compared every cycle against a cycle-count/arithmetic reference model.
module tb_serial_twos_complement_adder;

  logic clk = 1'b0;
  logic rst;

  logic       iv4, ir4, ov4, or4, co4, of4, busy4;
  logic [3:0] a4, b4, sum4;
  logic       iv8, ir8, ov8, or8, co8, of8, busy8;
  logic [7:0] a8, b8, sum8;

  int total = 0;
  int bad   = 0;

  // model: phase 0=idle 1=adding 2=result held
  int m_phase[2], m_left[2], m_sum[2], m_co[2], m_of[2];
  int p_sum[2], p_co[2], p_of[2], m_ops[2];

  serial_twos_complement_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .sum(sum4), .carry_out(co4),
    .overflow(of4), .busy(busy4)
  );

  serial_twos_complement_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .carry_out(co8),
    .overflow(of8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_left[k] = 0; m_sum[k] = 0; m_co[k] = 0; m_of[k] = 0;
  endtask

  task automatic model_step(input int k, input int w, input logic iv, input int ia,
                            input int ib, input logic ordy);
    int tot, sa, sb, ss;
    case (m_phase[k])
      0: if (iv) begin
        tot      = ia + ib;
        p_sum[k] = tot % (1 << w);
        p_co[k]  = (tot >> w) & 1;
        sa       = (ia >> (w - 1)) & 1;
        sb       = (ib >> (w - 1)) & 1;
        ss       = (p_sum[k] >> (w - 1)) & 1;
        p_of[k]  = ((sa == sb) && (ss != sa)) ? 1 : 0;
        m_co[k]  = 0;
        m_of[k]  = 0;
        m_left[k] = w;
        m_phase[k] = 1;
      end
      1: begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_phase[k] = 2;
          m_sum[k] = p_sum[k];
          m_co[k]  = p_co[k];
          m_of[k]  = p_of[k];
          m_ops[k]++;
        end
      end
      default: if (ordy) m_phase[k] = 0;
    endcase
  endtask

  task automatic check_dut(input int k, input logic ir, input logic bz, input logic ov,
                           input logic co, input logic of, input int sm);
    string p;
    p = (k == 0) ? "w4" : "w8";
    chk({p, "_in_ready"},  int'(ir), (m_phase[k] == 0) ? 1 : 0);
    chk({p, "_busy"},      int'(bz), (m_phase[k] == 1) ? 1 : 0);
    chk({p, "_out_valid"}, int'(ov), (m_phase[k] == 2) ? 1 : 0);
    chk({p, "_carry_out"}, int'(co), m_co[k]);
    chk({p, "_overflow"},  int'(of), m_of[k]);
    if (m_phase[k] != 1) chk({p, "_sum"}, sm, m_sum[k]);
  endtask

  // Compare process: outputs are checked against the model, then the model advances
  always @(negedge clk) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end
    check_dut(0, ir4, busy4, ov4, co4, of4, int'(sum4));
    check_dut(1, ir8, busy8, ov8, co8, of8, int'(sum8));
    if (!rst) begin
      model_step(0, 4, iv4, int'(a4), int'(b4), or4);
      model_step(1, 8, iv8, int'(a8), int'(b8), or8);
    end
  end

  task automatic run_op4(input int ia, input int ib, input logic ordy, output int lat);
    iv4 = 1'b1; a4 = ia[3:0]; b4 = ib[3:0]; or4 = ordy;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!ov4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect4(input string nm, input int s, input int c, input int o);
    chk({nm, "_sum"}, int'(sum4), s);
    chk({nm, "_carry"}, int'(co4), c);
    chk({nm, "_ovf"}, int'(of4), o);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int cyc;
    m_ops[0] = 0; m_ops[1] = 0;
    rst = 1'b1;
    iv4 = 1'b0; a4 = 4'd0; b4 = 4'd0; or4 = 1'b1;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(ir4), 1);
    chk("rst_out_valid", int'(ov4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_sum", int'(sum4), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op4(3, 2, 1'b1, lat);
    chk("t1_latency", lat, 4);
    expect4("t1", 5, 0, 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", int'(ov4), 0);
    chk("t1_sum_held", int'(sum4), 5);

    run_op4(7, 1, 1'b1, lat);
    expect4("t2a", 8, 0, 1);
    @(posedge clk); #1;
    run_op4(-8, -1, 1'b1, lat);
    expect4("t2b", 7, 1, 1);
    @(posedge clk); #1;
    run_op4(-1, 1, 1'b1, lat);
    expect4("t3a", 0, 1, 0);
    @(posedge clk); #1;
    run_op4(-4, -4, 1'b1, lat);
    expect4("t3b", 8, 1, 0);
    @(posedge clk); #1;

    run_op4(3, 4, 1'b0, lat);
    expect4("t4", 7, 0, 0);
    for (int i = 0; i < 10; i++) begin
      iv4 = (i == 3) ? 1'b1 : 1'b0;
      a4 = 4'd1; b4 = 4'd1;
      @(posedge clk); #1;
      chk("t4_hold_valid", int'(ov4), 1);
      chk("t4_hold_ready", int'(ir4), 0);
      chk("t4_hold_sum", int'(sum4), 7);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid", int'(ov4), 0);
    chk("t4_release_ready", int'(ir4), 1);
    chk("t4_release_sum", int'(sum4), 7);

    iv4 = 1'b1; a4 = 4'd5; b4 = 4'd6;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_in_ready", int'(ir4), 1);
    chk("t5_out_valid", int'(ov4), 0);
    chk("t5_busy", int'(busy4), 0);
    chk("t5_sum", int'(sum4), 0);
    chk("t5_carry", int'(co4), 0);
    chk("t5_ovf", int'(of4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op4(2, -3, 1'b1, lat);
    chk("t5_latency", lat, 4);
    expect4("t5", 15, 0, 0);
    @(posedge clk); #1;

    cyc = 0;
    while (m_ops[1] < 1000 && cyc < 40000) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8  = pick8();
      b8  = pick8();
      or8 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    chk("t6_ops_completed", (m_ops[1] >= 1000) ? 1 : 0, 1);
    repeat (12) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
